seq_mult: RTL and testbench
===========================

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: request a multiply; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH: multiplicand, captured on the edge that accepts start.
REQ-006 SHALL have port b, input, WIDTH: multiplier, captured on the same edge.
REQ-007 SHALL have port busy, output, 1: high while state is not IDLE.
REQ-008 SHALL have port done, output, 1: single-cycle pulse marking a new valid product.
REQ-009 SHALL have port product, output, 2*WIDTH: result, held stable until the next done.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, DONE.
REQ-011 SHALL move IDLE->CALC on a rising edge with start=1, latching a, b, clearing the accumulator and setting bit counter to 0.
REQ-012 SHALL, each CALC cycle, form partial-product row a AND b[cnt], add it to the accumulator shifted left by cnt, then increment cnt.
REQ-013 SHALL move CALC->DONE on the edge that processes bit WIDTH-1; DONE->IDLE on the next edge unconditionally.
REQ-014 SHALL assert done and load product from the accumulator in DONE only; latency is exactly WIDTH+1 edges from the accepting edge to done high.
REQ-015 SHALL ignore start in CALC and DONE; no queuing, no restart, latched operands unaffected.
REQ-016 SHALL accept start on the edge leaving DONE->IDLE only if start is high in the following IDLE cycle (back-to-back throughput: one op per WIDTH+2 cycles).
REQ-017 SHALL use fixed latency: zero operands and all-ones operands take identical cycles.
REQ-018 SHALL size the accumulator 2*WIDTH bits; no overflow is possible; counter is clog2(WIDTH) bits and SHALL NOT wrap inside an operation.
REQ-019 SHALL keep a and b inputs free to change after the accepting edge without affecting the result.

Reset
REQ-020 SHALL, on rst_n low at any time including mid-CALC, immediately force state=IDLE, busy=0, done=0, product=0, accumulator=0, counter=0.
REQ-021 SHALL remain in IDLE after rst_n deasserts until start is sampled; an aborted operation SHALL never produce done.

Configuration
REQ-022 SHALL compile signed support when macro SEQ_MULT_SIGNED_EN is defined: operands two's complement, row for b[WIDTH-1] subtracted instead of added, a sign-extended to 2*WIDTH, product two's complement.
REQ-023 SHALL, when SEQ_MULT_SIGNED_EN is undefined, treat operands as unsigned with no sign logic present; latency identical in both builds.

Structure
REQ-024 SHALL place the state enumeration type and default WIDTH constant in shared package seq_mult_pkg.
REQ-025 SHALL instantiate one sub-module pp_row (WIDTH-bit vector AND single bit -> WIDTH-bit row) for partial-product generation; all sequencing stays in seq_mult.

Verification
REQ-026 SHALL cover unsigned WIDTH=4: a=15, b=15, start one cycle -> done high exactly 5 edges later, product=8'hE1 (225), busy high 5 cycles.
REQ-027 SHALL cover zero: a=4'h9, b=0 -> product=8'h00, done at same 5-edge latency.
REQ-028 SHALL cover start held high during busy with a, b changed mid-op: a=3, b=5 accepted, then a=7, b=7 -> single done, product=8'h0F, next op starts only from IDLE.
REQ-029 SHALL cover reset mid-op: rst_n low on 2nd CALC cycle -> busy, done, product 0 same cycle; no done afterwards without new start.
REQ-030 SHALL cover SEQ_MULT_SIGNED_EN, WIDTH=4: a=4'h8 (-8), b=4'h7 -> product=8'hC8 (-56); a=4'h8, b=4'h8 -> product=8'h40 (64).
REQ-031 SHALL cover WIDTH=8 unsigned: a=8'hFF, b=8'hFF -> product=16'hFE01, done 9 edges after accept.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_pp_row.sv
// Partial-product row generator: every bit of vec gated by one multiplier bit.
module pp_row #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             bit_i,
  output logic [WIDTH-1:0] row_c
);

  // Gate the whole multiplicand with the selected multiplier bit.
  always_comb begin
    row_c = vec & {WIDTH{bit_i}};
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one multiplier bit per CALC cycle, fixed
// latency of WIDTH+1 edges from accept to done.
// Optional build macro: SEQ_MULT_SIGNED_EN selects two's-complement operands
// (top row subtracted, rows sign-extended); undefined gives plain unsigned.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PW-1:0]      product_q, product_d;

  logic [WIDTH-1:0]   row_c;
  logic [PW-1:0]      row_ext_c;
  logic               last_bit_c;

  pp_row #(.WIDTH(WIDTH)) u_pp_row (
    .vec   (a_q),
    .bit_i (b_q[cnt_q]),
    .row_c (row_c)
  );

  // Widen the current row to accumulator width.
  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    row_ext_c = {{WIDTH{row_c[WIDTH-1]}}, row_c};
`else
    row_ext_c = {{WIDTH{1'b0}}, row_c};
`endif
    last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      CALC: begin
`ifdef SEQ_MULT_SIGNED_EN
        if (last_bit_c) begin
          acc_d = acc_q - (row_ext_c << cnt_q);
        end else begin
          acc_d = acc_q + (row_ext_c << cnt_q);
        end
`else
        acc_d = acc_q + (row_ext_c << cnt_q);
`endif
        if (last_bit_c) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d   = IDLE;
        product_d = acc_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult at WIDTH=4 and WIDTH=8.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        start;
  logic [3:0]  a, b;
  logic        busy, done;
  logic [7:0]  product;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] product8;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    start = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    #2 rst_n = 1'b0;
    #2;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else n_pass++;
    n_total++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
    else n_pass++;
    n_total++;
    if (product !== 8'h00) $display("FAIL reset_product: got %h expected 00", product);
    else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy);
    else n_pass++;
  endtask

  // One 4-bit operation; inputs scrambled after the accepting edge.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic [7:0] exp, input string name);
    int done_edge, n_done, n_busy;
    logic [7:0] got;
    done_edge = -1; n_done = 0; n_busy = 0; got = 'x;
    a = ta; b = tb_v; start = 1'b1;
    tick();
    start = 1'b0; a = ~ta; b = ~tb_v;
    if (busy === 1'b1) n_busy++;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done === 1'b1) begin
        n_done++;
        if (done_edge < 0) begin
          done_edge = i;
          got = product;
        end
      end
      if (busy === 1'b1) n_busy++;
    end
    n_total++;
    if (done_edge != 5) $display("FAIL %s_latency: got %0d expected 5", name, done_edge);
    else n_pass++;
    n_total++;
    if (got !== exp) $display("FAIL %s_product: got %h expected %h", name, got, exp);
    else n_pass++;
    n_total++;
    if (n_busy != 5) $display("FAIL %s_busy_cycles: got %0d expected 5", name, n_busy);
    else n_pass++;
    n_total++;
    if (n_done != 1) $display("FAIL %s_done_pulses: got %0d expected 1", name, n_done);
    else n_pass++;
    n_total++;
    if (product !== exp) $display("FAIL %s_product_hold: got %h expected %h", name, product, exp);
    else n_pass++;
  endtask

  // start held high through the operation while operands change.
  task automatic test_start_held;
    int n_done;
    n_done = 0;
    a = 4'd3; b = 4'd5; start = 1'b1;
    tick();
    a = 4'd7; b = 4'd7;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    n_total++;
    if (n_done != 1 || done !== 1'b1)
      $display("FAIL held_done: got count %0d done %b expected 1 1", n_done, done);
    else n_pass++;
    n_total++;
    if (product !== 8'h0F) $display("FAIL held_product: got %h expected 0f", product);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL held_idle_gap: got busy %b expected 0", busy);
    else n_pass++;
    tick();
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL held_reaccept: got busy %b done %b expected 1 0", busy, done);
    else n_pass++;
    for (int i = 1; i <= 5; i++) tick();
    n_total++;
    if (done !== 1'b1 || product !== 8'h31)
      $display("FAIL held_second_op: got done %b product %h expected 1 31", done, product);
    else n_pass++;
    tick();
  endtask

  // Reset during the second CALC cycle aborts with no later done.
  task automatic test_reset_mid_op;
    int n_done, n_busy;
    n_done = 0; n_busy = 0;
    a = 4'hF; b = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy);
    else n_pass++;
    n_total++;
    if (done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", done);
    else n_pass++;
    n_total++;
    if (product !== 8'h00) $display("FAIL midrst_product: got %h expected 00", product);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) n_done++;
      if (busy === 1'b1) n_busy++;
    end
    n_total++;
    if (n_done != 0 || n_busy != 0)
      $display("FAIL midrst_quiet: got done %0d busy %0d expected 0 0", n_done, n_busy);
    else n_pass++;
  endtask

  task automatic test_width8;
    int done_edge;
    logic [15:0] exp;
    logic [15:0] got;
`ifdef SEQ_MULT_SIGNED_EN
    exp = 16'h0001;
`else
    exp = 16'hFE01;
`endif
    done_edge = -1; got = 'x;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (done8 === 1'b1 && done_edge < 0) begin
        done_edge = i;
        got = product8;
      end
    end
    n_total++;
    if (done_edge != 9) $display("FAIL w8_latency: got %0d expected 9", done_edge);
    else n_pass++;
    n_total++;
    if (got !== exp) $display("FAIL w8_product: got %h expected %h", got, exp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
`ifdef SEQ_MULT_SIGNED_EN
    run_op(4'h8, 4'h7, 8'hC8, "s_neg8x7");
    run_op(4'h8, 4'h8, 8'h40, "s_neg8xneg8");
    run_op(4'hF, 4'hF, 8'h01, "s_neg1xneg1");
    run_op(4'h9, 4'h0, 8'h00, "s_zero");
`else
    run_op(4'hF, 4'hF, 8'hE1, "u_15x15");
    run_op(4'h9, 4'h0, 8'h00, "u_zero");
    run_op(4'hD, 4'hB, 8'h8F, "u_13x11");
`endif
    test_start_held();
    test_reset_mid_op();
    test_width8();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
